// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the gray FIFO: credit-based read requests,
// latency-matched capture of memory data into a skid buffer, valid/ready out.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                    rd_clk,
    input  logic                    rst,
    input  logic                    empty,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_req_,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CRED_MAX = (CW+1)'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [CW-1:0]         buf_count;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         buf_count_nxt;
    logic [CW-1:0]         inflight_nxt;
    logic [MEM_RD_LAT-1:0] strobe_sr;
    logic [MEM_RD_LAT:0]   strobe_ext;
    logic [CW:0]           credit;
    logic                  cap;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic                  drop;

    // The controller already suppresses rd_en when empty.
    logic unused_empty;
    assign unused_empty = empty;

    assign strobe_ext    = {strobe_sr, rd_en};
    assign cap           = strobe_sr[MEM_RD_LAT-1];
    assign pop           = m_valid && m_ready;
    assign full          = (buf_count == CW'(DEPTH));
    assign push          = cap && (!full || pop);
    assign drop          = cap && full && !pop;
    assign buf_count_nxt = buf_count + CW'(push) - CW'(pop);
    assign inflight_nxt  = inflight + CW'(rd_en) - CW'(cap);
    assign credit        = {1'b0, buf_count_nxt} + {1'b0, inflight_nxt};

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            strobe_sr <= '0;
            head      <= '0;
            tail      <= '0;
            buf_count <= '0;
            inflight  <= '0;
            rd_req_   <= 1'b1;
            ovf       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            strobe_sr <= strobe_ext[MEM_RD_LAT-1:0];
            inflight  <= inflight_nxt;
            buf_count <= buf_count_nxt;
            if (push) begin
                store[tail] <= rd_data;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            // Two entries of headroom absorb the request/strobe pipeline.
            rd_req_ <= !(credit <= CRED_MAX);
        end
    end

    assign m_valid = (buf_count != '0);
    assign m_data  = store[head];
    assign level   = buf_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: instance A (DEPTH 4, latency 1)
// and instance B (DEPTH 8, latency 3) each behind a modelled read controller.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic empty = 1'b0;

    logic       rd_en   [2] = '{1'b0, 1'b0};
    logic [7:0] rd_data [2] = '{8'h00, 8'h00};
    logic       rd_req  [2];
    logic       m_valid [2];
    logic [7:0] m_data  [2];
    logic       ovf     [2];
    logic       m_ready_a = 1'b0;
    logic       m_ready_b = 1'b0;
    logic [2:0] level_a;
    logic [3:0] level_b;

    // commands, written by the main sequence only
    logic       auto_rd   [2] = '{1'b0, 1'b0};
    logic       frc       [2] = '{1'b0, 1'b0};
    int         limit     [2] = '{0, 0};
    int         seq_base  [2] = '{0, 0};
    logic [7:0] seq_start [2] = '{8'h00, 8'h00};
    logic       rnd_b = 1'b0;
    logic       rdy_b = 1'b0;

    // controller / memory model state
    int         issued [2] = '{0, 0};
    logic       dlv [2][4] = '{default: 1'b0};
    logic [7:0] dld [2][4] = '{default: 8'h00};
    logic       rq  [2];
    logic       en;
    int         lat;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         pops [2] = '{0, 0};

    int n_chk  = 0;
    int n_fail = 0;

    fifo_rd_stream #(.DATA_WIDTH(8), .DEPTH(4), .MEM_RD_LAT(1)) u_a (
        .rd_clk (clk),
        .rst    (rst),
        .empty  (empty),
        .rd_en  (rd_en[0]),
        .rd_data(rd_data[0]),
        .rd_req_(rd_req[0]),
        .m_valid(m_valid[0]),
        .m_ready(m_ready_a),
        .m_data (m_data[0]),
        .level  (level_a),
        .ovf    (ovf[0])
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .DEPTH(8), .MEM_RD_LAT(3)) u_b (
        .rd_clk (clk),
        .rst    (rst),
        .empty  (empty),
        .rd_en  (rd_en[1]),
        .rd_data(rd_data[1]),
        .rd_req_(rd_req[1]),
        .m_valid(m_valid[1]),
        .m_ready(m_ready_b),
        .m_data (m_data[1]),
        .level  (level_b),
        .ovf    (ovf[1])
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    // Read controller registers rd_req_; memory returns data after lat.
    always @(posedge clk) begin
        rq[0] = rd_req[0];
        rq[1] = rd_req[1];
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 3; i > 0; i--) begin
                dlv[k][i] = dlv[k][i-1];
                dld[k][i] = dld[k][i-1];
            end
            en = !rst && (issued[k] < limit[k])
                 && (frc[k] || (auto_rd[k] && !rq[k]));
            dlv[k][0] = en;
            dld[k][0] = seq_start[k] + 8'(issued[k] - seq_base[k]);
            if (en) begin
                if (k == 0) q_a.push_back(dld[k][0]);
                else        q_b.push_back(dld[k][0]);
                issued[k]++;
            end
            rd_en[k]   = en;
            lat        = (k == 0) ? 1 : 3;
            rd_data[k] = dlv[k][lat] ? dld[k][lat] : 8'hEE;
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready_b = rnd_b ? 1'($urandom_range(0, 1)) : rdy_b;
    end

    // Monitor: every accepted beat must match the oldest issued word.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (m_valid[0] && m_ready_a) begin
                check("a_pop_pending", 32'(q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    exp_a = q_a.pop_front();
                    check("a_data", 32'(m_data[0]), 32'(exp_a));
                end
                check("a_ovf", 32'(ovf[0]), 0);
                pops[0]++;
            end
            if (m_valid[1] && m_ready_b) begin
                check("b_pop_pending", 32'(q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    exp_b = q_b.pop_front();
                    check("b_data", 32'(m_data[1]), 32'(exp_b));
                end
                check("b_ovf", 32'(ovf[1]), 0);
                pops[1]++;
            end
        end
    end

    task automatic start(input int k, input logic [7:0] s, input int n,
                         input logic f);
        seq_base[k]  = issued[k];
        seq_start[k] = s;
        limit[k]     = issued[k] + n;
        frc[k]       = f;
        auto_rd[k]   = !f;
    endtask

    task automatic lat_probe(input int k, input int l);
        for (int i = 0; i <= l; i++) begin
            @(negedge clk);
            check($sformatf("lat%0d_early", k), 32'(m_valid[k]), 0);
        end
        @(negedge clk);
        check($sformatf("lat%0d_hit", k), 32'(m_valid[k]), 1);
        @(negedge clk);
        check($sformatf("lat%0d_after", k), 32'(m_valid[k]), 0);
    endtask

    task automatic drain(input int k, input int budget);
        int n;
        int qs;
        int lv;
        n = 0;
        forever begin
            qs = (k == 0) ? q_a.size() : q_b.size();
            lv = (k == 0) ? 32'(level_a) : 32'(level_b);
            if (n >= budget) break;
            if (issued[k] >= limit[k] && qs == 0 && lv == 0) break;
            @(negedge clk);
            n++;
        end
        check($sformatf("drain%0d_in_time", k), 32'(n < budget), 1);
    endtask

    initial begin
        int p;
        repeat (3) @(negedge clk);
        check("rst_req_a",   32'(rd_req[0]), 1);
        check("rst_valid_a", 32'(m_valid[0]), 0);
        check("rst_data_a",  32'(m_data[0]), 0);
        check("rst_level_a", 32'(level_a), 0);
        check("rst_ovf_a",   32'(ovf[0]), 0);
        check("rst_req_b",   32'(rd_req[1]), 1);
        check("rst_level_b", 32'(level_b), 0);

        rst = 1'b0;
        #1 check("req_hold_a", 32'(rd_req[0]), 1);
        @(negedge clk);
        check("req_low_a", 32'(rd_req[0]), 0);
        check("req_low_b", 32'(rd_req[1]), 0);

        m_ready_a = 1'b1;
        rdy_b     = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_level_a", 32'(level_a), 0);
        check("idle_valid_a", 32'(m_valid[0]), 0);

        start(0, 8'hA5, 1, 1'b1);
        lat_probe(0, 1);
        check("single_level_a", 32'(level_a), 0);

        m_ready_a = 1'b0;
        start(0, 8'h01, 1000, 1'b0);
        repeat (12) @(negedge clk);
        check("bp_level",  32'(level_a), 4);
        check("bp_req",    32'(rd_req[0]), 1);
        check("bp_ovf",    32'(ovf[0]), 0);
        check("bp_queued", 32'(q_a.size()), 4);
        check("bp_head",   32'(m_data[0]), 8'h01);
        limit[0] = issued[0];
        p = pops[0];
        m_ready_a = 1'b1;
        drain(0, 20);
        check("bp_pops", 32'(pops[0] - p), 4);
        @(negedge clk);
        check("bp_req_again", 32'(rd_req[0]), 0);

        p = pops[0];
        start(0, 8'h10, 20, 1'b0);
        drain(0, 200);
        check("stream_pops", 32'(pops[0] - p), 20);
        check("stream_ovf",  32'(ovf[0]), 0);

        start(1, 8'h3C, 1, 1'b1);
        lat_probe(1, 3);

        p = pops[1];
        rnd_b = 1'b1;
        start(1, 8'h40, 24, 1'b0);
        drain(1, 600);
        rnd_b = 1'b0;
        check("b_stream_pops", 32'(pops[1] - p), 24);
        check("b_stream_ovf",  32'(ovf[1]), 0);

        m_ready_a = 1'b0;
        start(0, 8'h70, 4, 1'b1);
        repeat (5) @(negedge clk);
        check("mid_level", 32'(level_a), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(level_a), 0);
        check("mid_rst_valid", 32'(m_valid[0]), 0);
        check("mid_rst_req",   32'(rd_req[0]), 1);
        check("mid_rst_data",  32'(m_data[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_level", 32'(level_a), 0);
        check("post_valid", 32'(m_valid[0]), 0);
        check("post_ovf",   32'(ovf[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
